des_decrypt_iter: RTL and testbench
===================================

# des_decrypt_iter

Iterative single-DES decryption engine: accepts a 64-bit ciphertext block and 64-bit key over a valid/ready handshake, runs the 16 Feistel rounds one per clock with the subkey schedule reversed (K16 first), and returns the 64-bit plaintext over a second valid/ready handshake. It sits beside the encryption datapath in the DES block and reuses the existing `sbox1`..`sbox8` lookup modules for the f-function.

## Interface
- No parameters; all widths are fixed by FIPS 46-3.
- `i_clk` in 1: the only clock; all state updates on the rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: ciphertext and key are valid.
- `o_ready` out 1: engine can accept a block; high only in IDLE.
- `i_data` in 64: ciphertext, bit 63 = DES bit 1.
- `i_key` in 64: key including parity bits; parity bits (8,16,..,64) are ignored.
- `o_valid` out 1: plaintext valid on `o_data`.
- `i_ready` in 1: downstream accepts `o_data`.
- `o_data` out 64: plaintext, bit 63 = DES bit 1.
- `i_encrypt` in 1: present only with `DES_DECRYPT_ENC_MODE_EN`; see Configuration.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: `o_ready`=1. On `i_valid & o_ready`: load L/R = IP(`i_data`) halves; load C/D = PC-1(`i_key`) halves; round counter = 0; go to ROUND. Inputs are sampled only on that edge.
- ROUND (16 cycles, counter 0..15): subkey = PC-2(C,D). L' = R; R' = L xor P(S(E(R) xor subkey)); S stage = eight instances `sbox1`..`sbox8`, sbox1 fed by bits 47:42 of E(R) xor subkey.
- Key schedule, decrypt: round 0 uses PC-2 of the loaded C/D directly (K16). After round k (k=0..14), C and D each rotate RIGHT by 1 for k in {0,7,14}, else by 2. No rotation after round 15. Total right rotation = 28 = identity.
- After counter 15: `o_data` register = FP(R16 ‖ L16) (halves swapped before FP); go to DONE.
- DONE: `o_valid`=1, `o_data` held stable until `i_valid`-independent `i_ready`=1; on `o_valid & i_ready` go to IDLE.
- `i_valid` ignored outside IDLE; no input queuing.
- Counter is 4 bits; it never wraps in ROUND (exit at 15).

## Timing
- Reset (asynchronous, any state including mid-ROUND): state=IDLE, counter=0, L/R/C/D=0, `o_data`=64'h0, `o_valid`=0, `o_ready`=1 once reset deasserts. In-flight block discarded; no output produced.
- Accept at edge N; rounds at edges N+1..N+16; `o_valid` high from edge N+16 (16-cycle latency from accept edge).
- Output consumed at edge M (`i_ready`=1, `o_valid`=1): `o_valid` low and `o_ready` high after edge M; next accept earliest at edge M+1.
- Throughput: one block per 18 cycles with `i_ready` tied high.
- `o_data` changes only on the FP load edge and on reset.
- Critical path: one round (E, xor, sbox, P, xor) in a single cycle.

## Configuration
- `DES_DECRYPT_ENC_MODE_EN` defined: `i_encrypt` port exists, sampled at accept. `i_encrypt`=1: round 0 first rotates C/D LEFT by 1 before PC-2, and rotations are LEFT by standard schedule (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) applied before each round's PC-2; result is encryption. `i_encrypt`=0: decryption exactly as above.
- Not defined: no `i_encrypt` port; decrypt only.

## Test plan
- Key 133457799BBCDFF1, ciphertext 85E813540F0AB405 -> `o_data`=0123456789ABCDEF, `o_valid` at accept+16.
- Key 0000000000000000, ciphertext 8CA64DE9C1B123A7 -> `o_data`=0000000000000000; repeat with key 0101010101010101 (parity-only differences) -> same result.
- Hold `i_ready`=0 for 20 cycles after `o_valid` -> `o_data` stable, `o_ready`=0, `i_valid` pulses with other data ignored; then `i_ready`=1 -> one transfer, `o_ready`=1 next cycle.
- Assert `i_rst_n`=0 asynchronously at round 7 -> `o_valid`=0, `o_data`=0 immediately; after release, new block decrypts correctly.
- Back-to-back blocks, `i_ready` tied 1, `i_valid` tied 1 -> accepts every 18 cycles, each output correct.
- With `DES_DECRYPT_ENC_MODE_EN`: `i_encrypt`=1, key 133457799BBCDFF1, data 0123456789ABCDEF -> 85E813540F0AB405.

Source files
------------

// File: rtl/des_decrypt_iter.sv
//==============================================================================
// Module      : des_decrypt_iter (with helper modules sbox1..sbox8)
// Description : Iterative single-DES decryption engine. One Feistel round per
//               clock, subkeys generated on the fly in reverse order (K16
//               first) by rotating C/D right. Valid/ready handshake on both
//               the input (ciphertext + key) and output (plaintext) sides.
//
// Ports       : i_clk      - clock, rising edge
//               i_rst_n    - asynchronous active-low reset
//               i_valid    - ciphertext/key valid
//               o_ready    - engine idle, can accept a block
//               i_data     - ciphertext, bit 63 = DES bit 1
//               i_key      - 64-bit key incl. parity bits (parity ignored)
//               o_valid    - plaintext valid
//               i_ready    - downstream accepts o_data
//               o_data     - plaintext, bit 63 = DES bit 1
//               i_encrypt  - (DES_DECRYPT_ENC_MODE_EN only) 1 = encrypt
//
// Options     : `define DES_DECRYPT_ENC_MODE_EN adds the i_encrypt port and a
//               forward (encryption) key schedule selected per block.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

//------------------------------------------------------------------------------
// S-boxes. Each table holds 64 nibbles, entry 0 in the top nibble, laid out
// row-major (row = {b5,b0}, column = b4..b1). Entry idx sits at bit offset
// 4*(63-idx), which is {~idx, 2'b00}.
//------------------------------------------------------------------------------
module sbox1 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

module sbox2 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

module sbox3 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

module sbox4 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

module sbox5 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

module sbox6 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

module sbox7 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

module sbox8 (
    input  logic [5:0] i_in,
    output logic [3:0] o_out
);
    localparam logic [255:0] c_TABLE =
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
    logic [5:0] w_idx;
    logic [7:0] w_shift;
    assign w_idx   = {i_in[5], i_in[0], i_in[4:1]};
    assign w_shift = {~w_idx, 2'b00};
    assign o_out   = c_TABLE[w_shift +: 4];
endmodule

//------------------------------------------------------------------------------
// Top level
//------------------------------------------------------------------------------
module des_decrypt_iter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [63:0] i_data,
    input  logic [63:0] i_key,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_data
`ifdef DES_DECRYPT_ENC_MODE_EN
    ,
    input  logic        i_encrypt
`endif
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ROUND = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Permutation tables in FIPS 46-3 notation: 1-based source bit numbers,
    // bit 1 being the MSB of the source vector.
    localparam int c_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
    localparam int c_FP [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
    localparam int c_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int c_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int c_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int c_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_IP[i])];
        return y;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - c_FP[i])];
        return y;
    endfunction

    function automatic logic [47:0] f_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - c_E[i])];
        return y;
    endfunction

    function automatic logic [31:0] f_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - c_P[i])];
        return y;
    endfunction

    // Parity bits (DES bits 8,16,..,64) are simply never selected.
    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - c_PC1[i])];
        return y;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - c_PC2[i])];
        return y;
    endfunction

    function automatic logic [27:0] f_rot_r(input logic [27:0] x, input logic by_one);
        return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

`ifdef DES_DECRYPT_ENC_MODE_EN
    function automatic logic [27:0] f_rot_l(input logic [27:0] x, input logic by_one);
        return by_one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction
`endif

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [63:0] r_data;
    logic        r_valid;
    logic        r_ready;

    logic [63:0] w_ip;
    logic [55:0] w_cd;
    logic        w_rshift1;
    logic [27:0] w_c_rnd;
    logic [27:0] w_d_rnd;
    logic [27:0] w_c_next;
    logic [27:0] w_d_next;
    logic [27:0] w_c_dec;
    logic [27:0] w_d_dec;
    logic [47:0] w_subkey;
    logic [47:0] w_sx;
    logic [31:0] w_s;
    logic [31:0] w_r_new;

    assign w_ip = f_ip(i_data);
    assign w_cd = f_pc1(i_key);

    // Reverse schedule: the shift undone after round k is the forward shift
    // of round 16-k, which is 1 for k = 0, 7, 14.
    assign w_rshift1 = (r_cnt == 4'd0) || (r_cnt == 4'd7) || (r_cnt == 4'd14);
    assign w_c_dec   = (r_cnt == 4'd15) ? r_c : f_rot_r(r_c, w_rshift1);
    assign w_d_dec   = (r_cnt == 4'd15) ? r_d : f_rot_r(r_d, w_rshift1);

`ifdef DES_DECRYPT_ENC_MODE_EN
    logic r_enc;
    logic w_lshift1;

    // Forward schedule rotates before the subkey is taken, so the rotated
    // value both feeds PC-2 this round and becomes the stored C/D.
    assign w_lshift1 = (r_cnt == 4'd0) || (r_cnt == 4'd1) ||
                       (r_cnt == 4'd8) || (r_cnt == 4'd15);
    assign w_c_rnd   = r_enc ? f_rot_l(r_c, w_lshift1) : r_c;
    assign w_d_rnd   = r_enc ? f_rot_l(r_d, w_lshift1) : r_d;
    assign w_c_next  = r_enc ? w_c_rnd : w_c_dec;
    assign w_d_next  = r_enc ? w_d_rnd : w_d_dec;
`else
    assign w_c_rnd   = r_c;
    assign w_d_rnd   = r_d;
    assign w_c_next  = w_c_dec;
    assign w_d_next  = w_d_dec;
`endif

    assign w_subkey = f_pc2({w_c_rnd, w_d_rnd});
    assign w_sx     = f_e(r_r) ^ w_subkey;

    sbox1 u_sbox1 (.i_in(w_sx[47:42]), .o_out(w_s[31:28]));
    sbox2 u_sbox2 (.i_in(w_sx[41:36]), .o_out(w_s[27:24]));
    sbox3 u_sbox3 (.i_in(w_sx[35:30]), .o_out(w_s[23:20]));
    sbox4 u_sbox4 (.i_in(w_sx[29:24]), .o_out(w_s[19:16]));
    sbox5 u_sbox5 (.i_in(w_sx[23:18]), .o_out(w_s[15:12]));
    sbox6 u_sbox6 (.i_in(w_sx[17:12]), .o_out(w_s[11:8]));
    sbox7 u_sbox7 (.i_in(w_sx[11:6]),  .o_out(w_s[7:4]));
    sbox8 u_sbox8 (.i_in(w_sx[5:0]),   .o_out(w_s[3:0]));

    assign w_r_new = r_l ^ f_p(w_s);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_l     <= 32'd0;
            r_r     <= 32'd0;
            r_c     <= 28'd0;
            r_d     <= 28'd0;
            r_data  <= 64'd0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
`ifdef DES_DECRYPT_ENC_MODE_EN
            r_enc   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_valid) begin
                        r_l     <= w_ip[63:32];
                        r_r     <= w_ip[31:0];
                        r_c     <= w_cd[55:28];
                        r_d     <= w_cd[27:0];
                        r_cnt   <= 4'd0;
                        r_ready <= 1'b0;
                        r_state <= c_ST_ROUND;
`ifdef DES_DECRYPT_ENC_MODE_EN
                        r_enc   <= i_encrypt;
`endif
                    end
                end
                c_ST_ROUND: begin
                    r_l <= r_r;
                    r_r <= w_r_new;
                    r_c <= w_c_next;
                    r_d <= w_d_next;
                    if (r_cnt == 4'd15) begin
                        // Final swap: R16 goes in the upper half before FP.
                        r_data  <= f_fp({w_r_new, r_r});
                        r_valid <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_ST_DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_des_decrypt_iter.sv
//==============================================================================
// Module      : tb_des_decrypt_iter
// Description : Directed self-checking bench for des_decrypt_iter using
//               published DES known-answer vectors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_des_decrypt_iter;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_data;
    logic [63:0] i_key;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_data;
`ifdef DES_DECRYPT_ENC_MODE_EN
    logic        enc;
`endif

    int n_checks;
    int n_fail;
    int cyc;

    // Back-to-back output capture
    logic        cap_en;
    int          n_cap;
    logic [63:0] cap_data [4];

    des_decrypt_iter dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_key    (i_key),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data)
`ifdef DES_DECRYPT_ENC_MODE_EN
        ,
        .i_encrypt(enc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!cap_en) begin
            n_cap <= 0;
        end else if (o_valid === 1'b1 && n_cap < 4) begin
            cap_data[n_cap] <= o_data;
            n_cap           <= n_cap + 1;
        end
    end

    // Accept one block, wait for the result, then consume it.
    task automatic run_block(input logic [63:0] d, input logic [63:0] k,
                             output logic [63:0] q, output int lat);
        lat = 0;
        @(negedge clk);
        i_data  = d;
        i_key   = k;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = '0;
        i_key   = '0;
        while (o_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q = o_data;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_key   = '0;
        #2;
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_o_valid: got %b expected 0", o_valid);
        end
        n_checks++;
        if (o_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_o_data: got %h expected 0", o_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_o_ready: got %b expected 1", o_ready);
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_valid: got %b expected 0", o_valid);
        end
    endtask

    task automatic test_basic;
        logic [63:0] q;
        int          lat;
        run_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, q, lat);
        n_checks++;
        if (q !== 64'h0123456789ABCDEF) begin
            n_fail++;
            $display("FAIL basic_data: got %h expected 0123456789abcdef", q);
        end
        n_checks++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 16", lat);
        end
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_handback: got valid=%b ready=%b expected valid=0 ready=1",
                     o_valid, o_ready);
        end
    endtask

    task automatic test_parity;
        logic [63:0] q;
        int          lat;
        run_block(64'h8CA64DE9C1B123A7, 64'h0000000000000000, q, lat);
        n_checks++;
        if (q !== 64'h0) begin
            n_fail++;
            $display("FAIL zero_key_data: got %h expected 0", q);
        end
        run_block(64'h8CA64DE9C1B123A7, 64'h0101010101010101, q, lat);
        n_checks++;
        if (q !== 64'h0) begin
            n_fail++;
            $display("FAIL parity_key_data: got %h expected 0", q);
        end
        n_checks++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL parity_latency: got %0d expected 16", lat);
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic saw_valid;
        @(negedge clk);
        i_data  = 64'h85E813540F0AB405;
        i_key   = 64'h133457799BBCDFF1;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        n = 0;
        while (o_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid_timeout: got %b expected 1", o_valid);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (o_data !== 64'h0123456789ABCDEF) begin
                n_fail++;
                $display("FAIL bp_hold_data[%0d]: got %h expected 0123456789abcdef", i, o_data);
            end
            n_checks++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold_flags[%0d]: got ready=%b valid=%b expected ready=0 valid=1",
                         i, o_ready, o_valid);
            end
            // Stray input traffic while busy must be ignored.
            i_valid = i[0];
            i_data  = {32'hDEADBEEF, 32'(i)};
            i_key   = 64'hFEDCBA9876543210;
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1",
                     o_valid, o_ready);
        end
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_single_transfer: got extra output expected none");
        end
    endtask

    task automatic test_async_reset;
        logic [63:0] q;
        int          lat;
        logic        saw_valid;
        @(negedge clk);
        i_data  = 64'h85E813540F0AB405;
        i_key   = 64'h133457799BBCDFF1;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_valid: got %b expected 0", o_valid);
        end
        n_checks++;
        if (o_data !== 64'h0) begin
            n_fail++;
            $display("FAIL areset_data: got %h expected 0", o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_ready: got %b expected 1", o_ready);
        end
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_valid === 1'b1) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_discard: got output expected none");
        end
        run_block(64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, q, lat);
        n_checks++;
        if (q !== 64'hFFFFFFFFFFFFFFFF) begin
            n_fail++;
            $display("FAIL areset_next_block: got %h expected ffffffffffffffff", q);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] ct  [4];
        logic [63:0] key [4];
        logic [63:0] pt  [4];
        int          acc [4];
        int          n;
        ct[0] = 64'h85E813540F0AB405; key[0] = 64'h133457799BBCDFF1; pt[0] = 64'h0123456789ABCDEF;
        ct[1] = 64'h0000000000000000; key[1] = 64'h0E329232EA6D0D73; pt[1] = 64'h8787878787878787;
        ct[2] = 64'h8CA64DE9C1B123A7; key[2] = 64'h0000000000000000; pt[2] = 64'h0000000000000000;
        ct[3] = 64'h7359B2163E4EDC58; key[3] = 64'hFFFFFFFFFFFFFFFF; pt[3] = 64'hFFFFFFFFFFFFFFFF;
        cap_en  = 1'b1;
        i_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            @(negedge clk);
            while (o_ready !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            n_checks++;
            if (o_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_timeout[%0d]: got %b expected 1", j, o_ready);
            end
            i_data  = ct[j];
            i_key   = key[j];
            i_valid = 1'b1;
            @(posedge clk);
            #1;
            acc[j] = cyc;
        end
        i_valid = 1'b0;
        n = 0;
        while (n_cap < 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        n_checks++;
        if (n_cap !== 4) begin
            n_fail++;
            $display("FAIL b2b_output_count: got %0d expected 4", n_cap);
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (cap_data[j] !== pt[j]) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", j, cap_data[j], pt[j]);
            end
        end
        for (int j = 1; j < 4; j++) begin
            n_checks++;
            if (acc[j] - acc[j-1] !== 18) begin
                n_fail++;
                $display("FAIL b2b_interval[%0d]: got %0d expected 18", j, acc[j] - acc[j-1]);
            end
        end
        cap_en  = 1'b0;
        i_ready = 1'b0;
    endtask

`ifdef DES_DECRYPT_ENC_MODE_EN
    task automatic test_encrypt;
        logic [63:0] q;
        int          lat;
        enc = 1'b1;
        run_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, q, lat);
        enc = 1'b0;
        n_checks++;
        if (q !== 64'h85E813540F0AB405) begin
            n_fail++;
            $display("FAIL encrypt_data: got %h expected 85e813540f0ab405", q);
        end
        run_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, q, lat);
        n_checks++;
        if (q !== 64'h0123456789ABCDEF) begin
            n_fail++;
            $display("FAIL decrypt_after_encrypt: got %h expected 0123456789abcdef", q);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cap_en   = 1'b0;
`ifdef DES_DECRYPT_ENC_MODE_EN
        enc      = 1'b0;
`endif
        test_reset();
        test_basic();
        test_parity();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
`ifdef DES_DECRYPT_ENC_MODE_EN
        test_encrypt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
